axon_delay_scheduler: RTL and testbench



---
 rtl/axon_delay_scheduler_if.sv | 33 +++
 rtl/axon_delay_scheduler.sv | 140 ++++++++++++++
 tb/tb_axon_delay_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axon_delay_scheduler_if.sv
// rtl/axon_delay_scheduler_if.sv - spike, config, drop and output handshake bundle for axon_delay_scheduler
//   spike_in   : per-channel spike pulse
//   cfg_*      : delay register write port (we / addr / delay)
//   out_*      : matured spike output, valid/ready handshake with channel id
//   chan_busy  : channel holds an in-flight spike
//   drop_*     : sticky dropped-spike flags and their clear strobe
interface axon_delay_scheduler_if #(
    parameter int N_CH = 4,
    parameter int DW   = 6
);
    localparam int AW = $clog2(N_CH);

    logic [N_CH-1:0] spike_in;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [DW-1:0]   cfg_delay;
    logic            out_valid;
    logic [AW-1:0]   out_id;
    logic            out_ready;
    logic [N_CH-1:0] chan_busy;
    logic [N_CH-1:0] drop_flags;
    logic            drop_clr;

    modport master (
        output spike_in, cfg_we, cfg_addr, cfg_delay, out_ready, drop_clr,
        input  out_valid, out_id, chan_busy, drop_flags
    );

    modport slave (
        input  spike_in, cfg_we, cfg_addr, cfg_delay, out_ready, drop_clr,
        output out_valid, out_id, chan_busy, drop_flags
    );
endinterface

// File: rtl/axon_delay_scheduler.sv
// rtl/axon_delay_scheduler.sv - per-channel axonal delay countdown with round-robin output arbitration
//   i_clock   : system clock, rising edge
//   i_reset_n : synchronous active-low reset
//   io_bus    : axon_delay_scheduler_if slave (spikes in, config writes, matured spike out, status)
module axon_delay_scheduler #(
    parameter int              N_CH          = 4,
    parameter int              DW            = 6,
    parameter logic [DW-1:0]   DEFAULT_DELAY = DW'(8)
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    axon_delay_scheduler_if.slave  io_bus
);
    localparam int AW = $clog2(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_READY = 2'd2
    } ch_state_t;

    ch_state_t       r_state    [N_CH];
    ch_state_t       w_state_nxt[N_CH];
    logic [DW-1:0]   r_cnt      [N_CH];
    logic [DW-1:0]   w_cnt_nxt  [N_CH];
    logic [DW-1:0]   r_delay    [N_CH];

    logic            r_out_valid, w_out_valid_nxt;
    logic [AW-1:0]   r_out_id,    w_out_id_nxt;
    logic [AW-1:0]   r_ptr,       w_ptr_nxt;
    logic [N_CH-1:0] r_drop,      w_drop_nxt;
    logic [N_CH-1:0] w_busy;
    logic [N_CH-1:0] w_drop_set;

    logic            w_free;
    logic            w_grant_vld;
    logic [AW-1:0]   w_grant;

    // The output register can take a new spike when it is empty or being drained this edge.
    always_comb begin
        w_free      = !r_out_valid || io_bus.out_ready;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!w_grant_vld && r_state[idx] == ST_READY) begin
                w_grant_vld = 1'b1;
                w_grant     = AW'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_busy[i]      = (r_state[i] != ST_IDLE);
            // A spike can only be taken in IDLE; anywhere else it is lost and flagged.
            w_drop_set[i]  = io_bus.spike_in[i] && w_busy[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (io_bus.spike_in[i]) begin
                        w_state_nxt[i] = ST_COUNT;
                        // Delay is snapshotted here, so later config writes leave this spike alone.
                        w_cnt_nxt[i]   = (r_delay[i] == '0) ? DW'(1) : r_delay[i];
                    end
                end
                ST_COUNT: begin
                    if (r_cnt[i] == DW'(1)) begin
                        w_state_nxt[i] = ST_READY;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] - DW'(1);
                    end
                end
                ST_READY: begin
                    if (w_free && w_grant_vld && w_grant == AW'(i)) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_id_nxt    = r_out_id;
        w_ptr_nxt       = r_ptr;
        // Set beats clear on the same bit.
        w_drop_nxt      = (io_bus.drop_clr ? '0 : r_drop) | w_drop_set;
        if (w_free) begin
            if (w_grant_vld) begin
                w_out_valid_nxt = 1'b1;
                w_out_id_nxt    = w_grant;
                w_ptr_nxt       = (w_grant == AW'(N_CH - 1)) ? '0 : w_grant + AW'(1);
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_delay[i] <= DEFAULT_DELAY;
            end
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_ptr       <= '0;
            r_drop      <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            if (io_bus.cfg_we && int'(io_bus.cfg_addr) < N_CH) begin
                r_delay[io_bus.cfg_addr] <= io_bus.cfg_delay;
            end
            r_out_valid <= w_out_valid_nxt;
            r_out_id    <= w_out_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_id     = r_out_id;
    assign io_bus.chan_busy  = w_busy;
    assign io_bus.drop_flags = r_drop;
endmodule

// File: tb/tb_axon_delay_scheduler.sv
// tb/tb_axon_delay_scheduler.sv - directed and randomized self-checking bench for axon_delay_scheduler
module tb_axon_delay_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    axon_delay_scheduler_if #(.N_CH(N), .DW(6)) bus();

    axon_delay_scheduler #(.N_CH(N), .DW(6), .DEFAULT_DELAY(6'd8)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each busy channel carries the edge number from which it may be granted.
    int      m_delay[N];
    bit      m_busy[N];
    longint  m_mature[N];
    bit      m_valid;
    int      m_id;
    int      m_ptr;
    bit [N-1:0] m_drop;
    longint  edge_n = 0;

    task automatic model_edge();
        bit free;
        int g;
        bit [N-1:0] nd;
        edge_n++;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_delay[i] = 8;
                m_busy[i]  = 0;
            end
            m_valid = 0; m_id = 0; m_ptr = 0; m_drop = '0;
            return;
        end
        free = !m_valid || bus.out_ready;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && m_busy[c] && edge_n >= m_mature[c]) g = c;
            end
        end
        nd = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.spike_in[i]) begin
                if (m_busy[i]) nd[i] = 1'b1;
                else begin
                    m_busy[i]   = 1;
                    m_mature[i] = edge_n + ((m_delay[i] == 0) ? 1 : m_delay[i]) + 1;
                end
            end
        end
        if (g >= 0) m_busy[g] = 0;
        m_drop = (bus.drop_clr ? '0 : m_drop) | nd;
        if (free) begin
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_ptr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        if (bus.cfg_we) m_delay[bus.cfg_addr] = int'(bus.cfg_delay);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.spike_in  = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_delay = '0;
        bus.out_ready = 1'b1;
        bus.drop_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'(ch);
        bus.cfg_delay = 6'(d);
        cycle();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        bus.spike_in = '1;
        bus.cfg_we   = 1'b1;
        cycle();
        cycle();
        drive_idle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", bus.out_id); else n_pass++;
        n_checks++; if (bus.chan_busy !== 4'b0) $display("FAIL reset_busy got=%b exp=0000", bus.chan_busy); else n_pass++;
        n_checks++; if (bus.drop_flags !== 4'b0) $display("FAIL reset_drop got=%b exp=0000", bus.drop_flags); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        cfg_write(0, 5);
        bus.spike_in = 4'b0001;
        cycle();
        bus.spike_in = '0;
        n_checks++; if (bus.chan_busy[0] !== 1'b1) $display("FAIL lat_busy_e0 got=%b exp=1", bus.chan_busy[0]); else n_pass++;
        for (int e = 1; e <= 9; e++) begin
            cycle();
            n_checks++; if (bus.out_valid !== (e == 6)) $display("FAIL lat_valid e=%0d got=%b exp=%b", e, bus.out_valid, (e == 6)); else n_pass++;
            if (e == 6) begin
                n_checks++; if (bus.out_id !== 2'd0) $display("FAIL lat_id got=%0d exp=0", bus.out_id); else n_pass++;
            end
            n_checks++; if (bus.chan_busy[0] !== (e <= 5)) $display("FAIL lat_busy e=%0d got=%b exp=%b", e, bus.chan_busy[0], (e <= 5)); else n_pass++;
        end
    endtask

    task automatic test_zero_delay();
        cfg_write(1, 0);
        cfg_write(2, 1);
        bus.spike_in = 4'b0110;
        cycle();
        bus.spike_in = '0;
        cycle();
        n_checks++; if (bus.chan_busy !== 4'b0110 || bus.out_valid !== 1'b0) $display("FAIL zd_e1 busy=%b valid=%b exp busy=0110 valid=0", bus.chan_busy, bus.out_valid); else n_pass++;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1) $display("FAIL zd_e2 valid=%b id=%0d exp 1/1", bus.out_valid, bus.out_id); else n_pass++;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2) $display("FAIL zd_e3 valid=%b id=%0d exp 1/2", bus.out_valid, bus.out_id); else n_pass++;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL zd_e4 valid=%b exp=0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < N; c++) cfg_write(c, 3);
        for (int b = 0; b < 2; b++) begin
            bus.spike_in = 4'b1111;
            cycle();
            bus.spike_in = '0;
            for (int e = 1; e <= 8; e++) begin
                cycle();
                if (e >= 4 && e <= 7) begin
                    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(e - 4)) $display("FAIL b2b burst=%0d e=%0d valid=%b id=%0d exp 1/%0d", b, e, bus.out_valid, bus.out_id, e - 4); else n_pass++;
                end else begin
                    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_idle burst=%0d e=%0d valid=%b exp=0", b, e, bus.out_valid); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.spike_in  = 4'b1000;
        cycle();
        bus.spike_in  = '0;
        for (int e = 1; e <= 14; e++) begin
            cycle();
            n_checks++; if (bus.out_valid !== (e >= 4)) $display("FAIL bp_valid e=%0d got=%b exp=%b", e, bus.out_valid, (e >= 4)); else n_pass++;
            if (e >= 4) begin
                n_checks++; if (bus.out_id !== 2'd3) $display("FAIL bp_id e=%0d got=%0d exp=3", e, bus.out_id); else n_pass++;
            end
            n_checks++; if (bus.chan_busy[3] !== (e <= 3)) $display("FAIL bp_busy e=%0d got=%b exp=%b", e, bus.chan_busy[3], (e <= 3)); else n_pass++;
        end
        bus.out_ready = 1'b1;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.chan_busy[3] !== 1'b0) $display("FAIL bp_release valid=%b busy=%b exp 0/0", bus.out_valid, bus.chan_busy[3]); else n_pass++;
    endtask

    task automatic test_drop();
        int outs;
        cfg_write(0, 10);
        outs = 0;
        bus.spike_in = 4'b0001;
        cycle();
        bus.spike_in = '0;
        for (int e = 1; e <= 15; e++) begin
            bus.spike_in = (e == 4) ? 4'b0001 : 4'b0000;
            cycle();
            if (bus.out_valid) begin
                outs++;
                n_checks++; if (e != 11 || bus.out_id !== 2'd0) $display("FAIL drop_out_time e=%0d id=%0d exp e=11 id=0", e, bus.out_id); else n_pass++;
            end
            if (e == 5) begin
                n_checks++; if (bus.drop_flags !== 4'b0001) $display("FAIL drop_set got=%b exp=0001", bus.drop_flags); else n_pass++;
            end
        end
        bus.spike_in = '0;
        n_checks++; if (outs != 1) $display("FAIL drop_out_count got=%0d exp=1", outs); else n_pass++;
        bus.spike_in = 4'b0001;
        cycle();
        bus.drop_clr = 1'b1;
        cycle();
        bus.spike_in = '0;
        n_checks++; if (bus.drop_flags[0] !== 1'b1) $display("FAIL drop_set_wins got=%b exp=1", bus.drop_flags[0]); else n_pass++;
        cycle();
        bus.drop_clr = 1'b0;
        n_checks++; if (bus.drop_flags !== 4'b0000) $display("FAIL drop_clear got=%b exp=0000", bus.drop_flags); else n_pass++;
        repeat (12) cycle();
    endtask

    task automatic test_cfg_inflight_reset();
        int outs;
        int first_id;
        do_reset();
        bus.spike_in = 4'b0001;
        cycle();
        bus.spike_in = '0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_delay = 6'd20;
            end
            cycle();
            bus.cfg_we = 1'b0;
            n_checks++; if (bus.out_valid !== (e == 9)) $display("FAIL inflight e=%0d valid=%b exp=%b", e, bus.out_valid, (e == 9)); else n_pass++;
        end
        bus.spike_in = 4'b0001;
        cycle();
        bus.spike_in = '0;
        cycle();
        bus.spike_in = 4'b0001;
        cycle();
        bus.spike_in = '0;
        n_checks++; if (bus.drop_flags[0] !== 1'b1) $display("FAIL pre_reset_drop got=%b exp=1", bus.drop_flags[0]); else n_pass++;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.chan_busy !== 4'b0 || bus.drop_flags !== 4'b0 || bus.out_id !== 2'd0)
            $display("FAIL midreset valid=%b busy=%b drop=%b id=%0d exp all 0", bus.out_valid, bus.chan_busy, bus.drop_flags, bus.out_id); else n_pass++;
        outs = 0;
        repeat (25) begin
            cycle();
            if (bus.out_valid) outs++;
        end
        n_checks++; if (outs != 0) $display("FAIL discarded got=%0d outputs exp=0", outs); else n_pass++;
        bus.spike_in = 4'b0011;
        cycle();
        bus.spike_in = '0;
        first_id = -1;
        for (int w = 0; w < 15 && first_id < 0; w++) begin
            cycle();
            if (bus.out_valid) first_id = int'(bus.out_id);
        end
        n_checks++; if (first_id != 0) $display("FAIL ptr_reset first_id=%0d exp=0", first_id); else n_pass++;
        repeat (3) cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) bus.spike_in[i] = ($urandom_range(0, 99) < 12);
            bus.cfg_we    = ($urandom_range(0, 99) < 8);
            bus.cfg_addr  = 2'($urandom_range(0, N - 1));
            bus.cfg_delay = 6'($urandom_range(0, 12));
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.drop_clr  = ($urandom_range(0, 99) < 5);
            cycle();
            n_checks++; if (bus.out_valid !== m_valid) $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.out_valid, m_valid); else n_pass++;
            n_checks++; if (bus.out_id !== 2'(m_id)) $display("FAIL rnd_id n=%0d got=%0d exp=%0d", n, bus.out_id, m_id); else n_pass++;
            for (int i = 0; i < N; i++) begin
                n_checks++; if (bus.chan_busy[i] !== m_busy[i]) $display("FAIL rnd_busy n=%0d ch=%0d got=%b exp=%b", n, i, bus.chan_busy[i], m_busy[i]); else n_pass++;
            end
            n_checks++; if (bus.drop_flags !== m_drop) $display("FAIL rnd_drop n=%0d got=%b exp=%b", n, bus.drop_flags, m_drop); else n_pass++;
        end
        drive_idle();
        rst_n = 1'b1;
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_latency();
        test_zero_delay();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_cfg_inflight_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
